// File: rtl/wr_ptr_gray_gen_if.sv
// Write-side pointer bundle between the FIFO producer and wr_ptr_gray_gen.
// master: producer / read-domain side that drives requests and the read pointer.
// slave:  the pointer generator itself.
interface wr_ptr_gray_gen_if #(
  parameter int unsigned ADDR_SIZE = 4
) ();

  logic                 wr_en;
  logic [ADDR_SIZE:0]   rptr_gray;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   wptr_gray;
  logic                 wr_accept;
  logic                 full;
  logic                 overflow;

  modport master (
    output wr_en,
    output rptr_gray,
    input  waddr,
    input  wptr_gray,
    input  wr_accept,
    input  full,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  rptr_gray,
    output waddr,
    output wptr_gray,
    output wr_accept,
    output full,
    output overflow
  );

endinterface

// File: rtl/wr_ptr_gray_gen.sv
// Write-side pointer generator for an asynchronous FIFO.
// Holds the binary write pointer, drives the registered RAM write address, publishes
// the Gray-coded pointer to the read domain and derives registered full / sticky
// overflow flags from the read-domain Gray pointer.
// Optional macro WPTR_SYNC_EN: when defined, rptr_gray passes through a two-flop
// synchronizer before the full compare (full release is then two cycles later).
module wr_ptr_gray_gen #(
  parameter int unsigned ADDR_SIZE = 4
) (
  input logic           clk,
  input logic           rst_n,
  wr_ptr_gray_gen_if.slave bus
);

  localparam int unsigned PtrW = ADDR_SIZE + 1;

  logic [PtrW-1:0]      wbin_q, wbin_d;
  logic [PtrW-1:0]      gray_d;
  logic [PtrW-1:0]      wptr_gray_q;
  logic [ADDR_SIZE-1:0] waddr_q;
  logic                 full_q, full_d;
  logic                 overflow_q, overflow_d;
  logic                 wr_accept;
  logic [PtrW-1:0]      rq;
  logic [PtrW-1:0]      full_pattern;

`ifdef WPTR_SYNC_EN
  logic [PtrW-1:0] rsync1_q, rsync2_q;

  // Two-flop synchronizer bringing the read pointer into the write clock domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsync1_q <= '0;
      rsync2_q <= '0;
    end else begin
      rsync1_q <= bus.rptr_gray;
      rsync2_q <= rsync1_q;
    end
  end

  assign rq = rsync2_q;
`else
  // Integrator supplies an already-synchronized read pointer.
  assign rq = bus.rptr_gray;
`endif

  // Next pointer, Gray encoding and full/overflow next-state.
  always_comb begin
    wr_accept    = bus.wr_en & ~full_q;
    wbin_d       = wbin_q + PtrW'(wr_accept);
    gray_d       = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_pattern = {~rq[ADDR_SIZE:ADDR_SIZE-1], rq[ADDR_SIZE-2:0]};
    full_d       = (gray_d == full_pattern);
    overflow_d   = overflow_q | (bus.wr_en & full_q);
  end

  // Pointer and flag registers; reset discards all pointer state on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin_q      <= '0;
      waddr_q     <= '0;
      wptr_gray_q <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      waddr_q     <= wbin_d[ADDR_SIZE-1:0];
      wptr_gray_q <= gray_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.wr_accept = wr_accept;
  assign bus.waddr     = waddr_q;
  assign bus.wptr_gray = wptr_gray_q;
  assign bus.full      = full_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: doc/wr_ptr_gray_gen.md
# wr_ptr_gray_gen

- Write-side pointer generator for the asynchronous FIFO.
- Keeps a binary write pointer and drives the binary RAM write address.
- Converts the pointer to Gray code for the read clock domain; this block is the encoder for the existing Gray-to-binary path on the read side.
- Compares the registered Gray pointer against the read-domain Gray pointer to produce a registered full flag and a sticky overflow flag.

## Interface

Parameters:
- ADDR_SIZE, 4, RAM address width. FIFO depth is 2^ADDR_SIZE. Pointers are ADDR_SIZE+1 bits.

Ports:
- clk  input  1  write-domain clock. All state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- wr_en  input  1  write request from the producer.
- rptr_gray  input  ADDR_SIZE+1  read pointer in Gray code, from the read domain.
- waddr  output  ADDR_SIZE  binary RAM write address, registered.
- wptr_gray  output  ADDR_SIZE+1  write pointer in Gray code, registered, sent to the read domain.
- wr_accept  output  1  combinational, equals wr_en & ~full. The RAM write strobe.
- full  output  1  FIFO full, registered.
- overflow  output  1  sticky flag: a write was attempted while full.

## Operation

- Internal state: binary pointer wbin, ADDR_SIZE+1 bits.
- Increment: wbin_next = wbin + wr_accept. Addition is modulo 2^(ADDR_SIZE+1); the pointer wraps from all-ones to 0.
- Gray conversion: gray_next = (wbin_next >> 1) ^ wbin_next.
- Registered outputs:
  - wptr_gray <= gray_next.
  - waddr <= wbin_next[ADDR_SIZE-1:0].
- Full compare uses rq = the compare copy of rptr_gray (see Configuration):
  - full <= (gray_next == {~rq[ADDR_SIZE:ADDR_SIZE-1], rq[ADDR_SIZE-2:0]}).
  - In words: the two MSBs are inverted and the remaining bits are equal.
- Overflow: overflow <= overflow | (wr_en & full). It clears only on reset.
- Gray invariant: successive wptr_gray values differ in exactly one bit, including across the wrap.
- Simultaneous wr_en and full: the write is dropped, wbin holds, overflow sets.
- Simultaneous final write and read-pointer advance: full is evaluated from gray_next against the current rq; no special priority.
- Empty detection is not done here; it belongs to the read side.

## Timing

- Reset, when rst_n is sampled low at a rising edge:
  - wbin = 0, waddr = 0, wptr_gray = 0.
  - full = 0, overflow = 0.
  - Reset mid-operation discards all pointer state on that edge.
  - The read side must be reset in the same window.
- Write latency: a write accepted at edge k shows on waddr, wptr_gray and full from edge k+1.
- Full assertion: full rises on the same edge that registers the Nth outstanding write, where N = 2^ADDR_SIZE. The next wr_en is therefore refused.
- Full release, with a change on rptr_gray stable before edge k:
  - Macro off: full deasserts at edge k.
  - Macro on: full deasserts at edge k+2.
  - The release is pessimistic and never early.
- wr_accept is combinational from wr_en and the full register; it has no path from rptr_gray.

## Configuration

- Macro: WPTR_SYNC_EN.
- Defined:
  - rptr_gray passes through a two-flop synchronizer clocked by clk.
  - Both flops reset to 0 on rst_n low.
  - rq is the second flop's output.
  - Adds 2 cycles to full release.
- Undefined:
  - rq = rptr_gray directly.
  - The integrator must supply an already-synchronized pointer, as in single-clock builds.

## Test plan

ADDR_SIZE = 4 throughout.

- Reset: hold rst_n = 0 for 2 edges with wr_en = 1 -> waddr = 0, wptr_gray = 5'b00000, full = 0, overflow = 0.
- Fill: rptr_gray = 0, wr_en = 1 for 16 edges -> waddr counts 1..15 then 0. After the 16th write: wptr_gray = 5'b11000, full = 1, wr_accept = 0.
- Overflow: from full, one more wr_en -> waddr and wptr_gray unchanged, overflow = 1. Overflow stays 1 after rptr_gray advances and more writes are accepted.
- Release: from full, set rptr_gray = 5'b00001 -> full = 0 after 1 edge (macro off) or 3 edges (macro on). Exactly one further write is accepted before full returns.
- Wrap and Gray check: stream 40 writes while keeping rptr_gray 8 behind -> every wptr_gray step changes exactly one bit. Binary 31 maps to Gray 5'b10000, then the pointer wraps to 5'b00000. full is never set.
- Mid-op reset: after 7 writes, assert rst_n = 0 for one edge -> all outputs return to 0 on that edge. Writing resumes from waddr 0.
